// File: rtl/mem_preload_dump.sv
// Preload/dump engine beside the CPU: streams bytes into RAM, then replays RAM
// words and the register file as a handshaked word stream while holding the CPU.
module mem_preload_dump #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int NUM_REGS   = 16,
    parameter int REG_SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start_load,
    input  logic                    start_dump,
    input  logic [ADDR_W-1:0]       dump_end_addr,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    output logic [REG_SEL_W-1:0]    reg_sel,
    input  logic [31:0]             reg_data,
    output logic                    out_valid,
    output logic [WORD_BYTES*8-1:0] out_data,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    out_is_reg,
    input  logic                    out_ready,
    output logic                    word_done,
    output logic [WORD_BYTES*8-1:0] load_word,
    output logic                    busy,
    output logic                    cpu_hold,
    output logic                    done
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0]     LAST_LANE  = CNT_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0]    ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0]    WORD_STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [REG_SEL_W-1:0] LAST_REG   = REG_SEL_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT, REG_RD, REG_OUT, DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     ptr;
    logic [CNT_W-1:0]      lane;
    logic [WORD_W-1:0]     lbuf;
    logic [REG_SEL_W-1:0]  idx;
    logic                  accept;
    logic                  load_exit;
    logic [ADDR_W-1:0]     end_base;

    // Byte k of a word lands in the most-significant free byte (big-endian).
    function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  k,
                                                   input logic [7:0]        b);
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (k == CNT_W'(i)) begin
                r[8*(WORD_BYTES-1-i) +: 8] = b;
            end
        end
        return r;
    endfunction

    assign accept    = (state == LOAD) && in_valid;
    assign load_exit = accept && (in_last || (ptr == '1));
    assign end_base  = dump_end_addr & ~ALIGN_MASK;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_load) begin
                    state_nxt = LOAD;
                end else if (start_dump) begin
                    state_nxt = DUMP_RD;
                end
            end
            LOAD:      if (load_exit) state_nxt = DONE;
            DUMP_RD:   if (lane == LAST_LANE) state_nxt = DUMP_WAIT;
            DUMP_WAIT: state_nxt = DUMP_OUT;
            DUMP_OUT: begin
                if (out_ready) begin
                    state_nxt = (ptr == end_base) ? REG_RD : DUMP_RD;
                end
            end
            REG_RD:    state_nxt = REG_OUT;
            REG_OUT: begin
                if (out_ready) begin
                    state_nxt = (idx == LAST_REG) ? DONE : REG_RD;
                end
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        reg_sel    = '0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_is_reg = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                mem_addr  = ptr;
                mem_we    = in_valid;
                mem_wdata = in_valid ? in_data : 8'h00;
            end
            DUMP_RD:  mem_addr = ptr + ADDR_W'(lane);
            DUMP_OUT: begin
                out_valid = 1'b1;
                out_addr  = ptr;
            end
            REG_RD:   reg_sel = idx;
            REG_OUT: begin
                out_valid  = 1'b1;
                out_is_reg = 1'b1;
                out_addr   = ADDR_W'(idx);
            end
            DONE:     done = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (state != IDLE);
    assign cpu_hold = busy;

    // ptr is the write pointer during load and the word base during dump;
    // lane counts bytes within the current word in both directions.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr       <= '0;
            lane      <= '0;
            lbuf      <= '0;
            idx       <= '0;
            out_data  <= '0;
            word_done <= 1'b0;
            load_word <= '0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load || start_dump) begin
                        ptr  <= '0;
                        lane <= '0;
                        lbuf <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ptr <= ptr + 1'b1;
                        if ((lane == LAST_LANE) || load_exit) begin
                            word_done <= 1'b1;
                            load_word <= set_lane(lbuf, lane, in_data);
                            lbuf      <= '0;
                            lane      <= '0;
                        end else begin
                            lbuf <= set_lane(lbuf, lane, in_data);
                            lane <= lane + 1'b1;
                        end
                    end
                end
                DUMP_RD: begin
                    if (lane != '0) begin
                        out_data <= set_lane(out_data, lane - 1'b1, mem_rdata);
                    end
                    lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
                end
                DUMP_WAIT: out_data <= set_lane(out_data, LAST_LANE, mem_rdata);
                DUMP_OUT: begin
                    if (out_ready) begin
                        if (ptr == end_base) begin
                            idx <= '0;
                        end else begin
                            ptr <= ptr + WORD_STEP;
                        end
                    end
                end
                REG_RD:  out_data <= WORD_W'(reg_data);
                REG_OUT: begin
                    if (out_ready && (idx != LAST_REG)) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_preload_dump.sv
// Randomised bench for mem_preload_dump: RAM/register environment plus a
// list-level reference model of expected RAM contents, load words and dump beats.
module tb_mem_preload_dump;

    localparam int ADDR_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int NUM_REGS   = 16;
    localparam int REG_SEL_W  = 4;

    logic        clk;
    logic        clr;
    logic        start_load;
    logic        start_dump;
    logic [7:0]  dump_end_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [3:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_addr;
    logic        out_is_reg;
    logic        out_ready;
    logic        word_done;
    logic [31:0] load_word;
    logic        busy;
    logic        cpu_hold;
    logic        done;

    mem_preload_dump #(
        .ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES), .NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)
    ) dut (
        .clk(clk), .clr(clr), .start_load(start_load), .start_dump(start_dump),
        .dump_end_addr(dump_end_addr), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .reg_sel(reg_sel),
        .reg_data(reg_data), .out_valid(out_valid), .out_data(out_data),
        .out_addr(out_addr), .out_is_reg(out_is_reg), .out_ready(out_ready),
        .word_done(word_done), .load_word(load_word), .busy(busy),
        .cpu_hold(cpu_hold), .done(done)
    );

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] regs    [16];

    logic [31:0] wd_q[$];
    logic [31:0] expw_q[$];
    logic [40:0] beat_q[$];
    logic [40:0] exp_q[$];
    int          bcyc_q[$];
    logic [7:0]  ld_bytes[$];

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign reg_data = regs[reg_sel];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output-stream monitor: records beats, load words and done pulses, and
    // checks that a stalled beat stays valid and unchanged.
    initial begin
        logic        pending;
        logic [40:0] held;
        pending = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (clr) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_beat", 64'({out_is_reg, out_addr, out_data}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    beat_q.push_back({out_is_reg, out_addr, out_data});
                    bcyc_q.push_back(cyc);
                end
                pending = out_valid && !out_ready;
                held    = {out_is_reg, out_addr, out_data};
                if (word_done) wd_q.push_back(load_word);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic do_load(input int last_idx, input int gap_pct, input logic both);
        int   i, acc_n, first_acc, last_acc, idle_n, d0, n_exp;
        logic acc;
        wd_q.delete();
        beat_q.delete();
        expw_q.delete();
        d0 = done_cnt; i = 0; acc_n = 0; first_acc = -1; last_acc = -1; idle_n = 0;
        n_exp = (last_idx >= 0) ? last_idx + 1 : ld_bytes.size();
        if (n_exp > 256) n_exp = 256;
        for (int w = 0; w * 4 < n_exp; w++) begin
            logic [31:0] word;
            word = '0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < n_exp) word[8*(3-b) +: 8] = ld_bytes[w*4+b];
            expw_q.push_back(word);
        end
        for (int k = 0; k < n_exp; k++) ref_mem[k] = ld_bytes[k];

        start_load = 1'b1;
        start_dump = both;
        @(posedge clk); #1;
        start_load = 1'b0;
        start_dump = 1'b0;
        if (both) begin
            chk("both_in_ready", 64'(in_ready), 64'd1);
            chk("both_busy", 64'(busy), 64'd1);
        end
        for (int c = 0; c < 3000 && i < ld_bytes.size() && idle_n < 8; c++) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = ld_bytes[i];
            in_last  = (i == last_idx);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (!in_ready) idle_n++;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                acc_n++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        for (int c = 0; c < 20 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
        end
        chk("load_done_seen", 64'(done_cnt != d0), 64'd1);
        chk("load_accepted", 64'(acc_n), 64'(n_exp));
        chk("load_done_time", 64'(done_cyc), 64'(last_acc + 1));
        if (gap_pct == 0) chk("load_consecutive", 64'(last_acc - first_acc), 64'(acc_n - 1));
        chk("load_in_ready_after", 64'(in_ready), 64'd0);
        chk("load_busy_after", 64'({busy, cpu_hold}), 64'd0);
        @(posedge clk); #1;
        chk("load_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("load_no_beats", 64'(beat_q.size()), 64'd0);
        chk("load_word_count", 64'(wd_q.size()), 64'(expw_q.size()));
        for (int k = 0; k < wd_q.size() && k < expw_q.size(); k++)
            chk("load_word", 64'(wd_q[k]), 64'(expw_q[k]));
        for (int k = 0; k < n_exp; k++) chk("ram_byte", 64'(ram[k]), 64'(ref_mem[k]));
    endtask

    task automatic do_dump(input logic [7:0] end_addr, input int rdy_pct, input logic stall2);
        int d0, stall_n, nmem;
        beat_q.delete();
        bcyc_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        stall_n = 0;
        for (int a = 0; a < 256; a += 4) begin
            exp_q.push_back({1'b0, 8'(a), ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]});
            if (a == int'(end_addr & 8'hFC)) break;
        end
        nmem = exp_q.size();
        for (int r = 0; r < NUM_REGS; r++) exp_q.push_back({1'b1, 8'(r), regs[r]});

        dump_end_addr = end_addr;
        start_dump = 1'b1;
        @(posedge clk); #1;
        start_dump = 1'b0;
        for (int c = 0; c < 6000 && done_cnt == d0; c++) begin
            if (stall2 && beat_q.size() == 1 && out_valid && stall_n < 3) begin
                out_ready = 1'b0;
                stall_n++;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("dump_done_seen", 64'(done_cnt != d0), 64'd1);
        chk("dump_beat_count", 64'(beat_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < beat_q.size() && k < exp_q.size(); k++)
            chk("dump_beat", 64'(beat_q[k]), 64'(exp_q[k]));
        if (stall2) chk("dump_stalls", 64'(stall_n), 64'd3);
        if (rdy_pct == 100 && !stall2 && nmem >= 2 && bcyc_q.size() >= 2)
            chk("dump_word_cycles", 64'(bcyc_q[1] - bcyc_q[0]), 64'd6);
        if (rdy_pct == 100 && !stall2 && bcyc_q.size() > nmem + 1)
            chk("dump_reg_cycles", 64'(bcyc_q[nmem+1] - bcyc_q[nmem]), 64'd2);
        chk("dump_busy_after", 64'({busy, cpu_hold, out_valid}), 64'd0);
        @(posedge clk); #1;
        chk("dump_done_pulses", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        clr = 1'b1;
        start_load = 1'b0;
        start_dump = 1'b0;
        dump_end_addr = 8'h00;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) regs[r] = 32'(r) * 32'h11111111;
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({busy, cpu_hold, in_ready, out_valid, out_is_reg, mem_we, word_done, done}), 64'd0);
        chk("rst_data", 64'({out_data, load_word}), 64'd0);
        chk("rst_addr", 64'({mem_addr, out_addr, reg_sel, mem_wdata}), 64'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Eight sequential bytes, two full words
        ld_bytes.delete();
        for (int k = 0; k < 8; k++) ld_bytes.push_back(8'(k));
        do_load(7, 0, 1'b0);

        // Dump two words plus registers, stalling the second beat
        do_dump(8'h05, 100, 1'b1);

        // Partial final word with input gaps
        ld_bytes.delete();
        for (int k = 0; k < 6; k++) ld_bytes.push_back(8'hA0 + 8'(k));
        do_load(5, 40, 1'b0);

        // Simultaneous start requests: load must win
        ld_bytes.delete();
        for (int k = 0; k < 4; k++) ld_bytes.push_back(8'($urandom()));
        do_load(3, 0, 1'b1);

        // Abort in DUMP_OUT, then restart from address 0
        dump_end_addr = 8'h04;
        out_ready = 1'b0;
        start_dump = 1'b1;
        @(posedge clk); #1;
        start_dump = 1'b0;
        for (int c = 0; c < 30 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("abort_reached_out", 64'(out_valid), 64'd1);
        clr = 1'b1;
        #1;
        chk("abort_outputs", 64'({out_valid, busy, cpu_hold}), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        out_ready = 1'b1;
        do_dump(8'h04, 100, 1'b0);
        if (beat_q.size() > 0) chk("restart_addr", 64'(beat_q[0][39:32]), 64'd0);

        // Address wrap: offer more bytes than the RAM holds, no in_last
        ld_bytes.delete();
        for (int k = 0; k < 260; k++) ld_bytes.push_back(8'($urandom()));
        do_load(-1, 30, 1'b0);

        for (int r = 0; r < NUM_REGS; r++) regs[r] = $urandom();
        do_dump(8'($urandom_range(255)), 70, 1'b0);

        repeat (3) begin
            int n;
            n = $urandom_range(23, 1);
            ld_bytes.delete();
            for (int k = 0; k < n; k++) ld_bytes.push_back(8'($urandom()));
            do_load(n - 1, 25, 1'b0);
            do_dump(8'($urandom_range(40, 4)), 100, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
